alu_add_sequencer: RTL and testbench
====================================

Name: alu_add_sequencer

Overview:
Sequences the 8-bit relay adder unit (a ripple chain of adder blocks) for the instruction sequencer. It accepts one add-class operation at a time, latches the operands and drives them onto the adder's B/C/carry-in lines, then waits a programmable relay settle time. It samples the sum and carry, updates the condition flags, and pulses the load strobe of the destination register (A or D).

Parameters:
WIDTH, 8, datapath width of adder unit and operands
SETTLE_CYCLES, 4, clocks the adder inputs are held stable before sampling; legal range 1..15

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  operation request; accepted only when busy=0
func  input  2  00 ADD (B+C), 01 INC (B+1), 10 ADC (B+C+carry_flag), 11 DEC (B+all-ones)
dest  input  1  0 = load A, 1 = load D
b_val  input  WIDTH  B operand
c_val  input  WIDTH  C operand; ignored for INC/DEC
adder_b  output  WIDTH  to adder unit B inputs
adder_c  output  WIDTH  to adder unit C inputs
adder_carry_in  output  1  to adder bit-0 carry-in
adder_sum  input  WIDTH  from adder unit
adder_carry_out  input  1  from adder bit WIDTH-1
result  output  WIDTH  registered captured sum
load_a  output  1  one-cycle load strobe, A register
load_d  output  1  one-cycle load strobe, D register
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
carry_flag  output  1  registered carry
zero_flag  output  1  registered result==0
sign_flag  output  1  registered result MSB
overflow_flag  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset values: every output 0. Internal operand/func/dest registers 0. State = IDLE, settle counter 0.
- States: IDLE -> LOAD -> SETTLE -> CAPTURE -> DONE -> IDLE.
- IDLE: if start=1, latch b_val, c_val, func, dest. Next state LOAD. start=0 stays IDLE.
- LOAD (1 cycle): drive adder_b = latched B. Drive adder_c per func: ADD/ADC = latched C, INC = 0, DEC = all-ones. Drive adder_carry_in: INC = 1, ADC = current carry_flag, else 0. Load counter with SETTLE_CYCLES-1.
- adder_b/adder_c/adder_carry_in hold their values unchanged from LOAD through CAPTURE. They return to 0 on entry to DONE.
- SETTLE: decrement counter each cycle. Leave when counter==0; exactly SETTLE_CYCLES cycles in SETTLE.
- CAPTURE (1 cycle):
  - result <= adder_sum; carry_flag <= adder_carry_out; zero_flag <= (adder_sum==0); sign_flag <= adder_sum[WIDTH-1].
  - load_a=1 if dest=0, else load_d=1. The strobe is combinational in this cycle, concurrent with the result register update; the destination samples adder_sum directly.
- DONE (1 cycle): done=1, then IDLE.
- Latency: start sampled at edge N. load_x high in cycle N+SETTLE_CYCLES+2. done high in cycle N+SETTLE_CYCLES+3. Next start is accepted in the cycle after done (earliest edge N+SETTLE_CYCLES+4).
- start while busy=1: ignored, not queued. Inputs change freely while busy without effect.
- Flags change only in CAPTURE. They hold between operations.
- ADC uses carry_flag as registered before this operation's CAPTURE.
- Carry semantics: DEC carry_out=1 means no borrow.
- Reset in any state: next cycle IDLE. No load_a/load_d/done pulse is emitted. Flags and result cleared.
- load_a and load_d are never high together. done is never high in the same cycle as a load strobe.

Optional Feature:
Macro ALU_OVERFLOW_FLAG_EN.
- Defined: overflow_flag updated in CAPTURE as (effective B MSB == effective C MSB) && (adder_sum MSB != B MSB), where effective C is the value driven on adder_c. It resets to 0.
- Undefined: overflow_flag is constant 0; no overflow logic is synthesized.

Test Plan:
1. SETTLE_CYCLES=4: ADD 0x3C+0x05, dest=0, start at edge 0 -> load_a high cycle 6, done high cycle 7, result=0x41, C=0 Z=0 S=0, load_d never high.
2. ADD 0xFF+0x01, dest=1 -> result=0x00, C=1, Z=1, S=0, load_d single pulse. Then ADC 0x10+0x20 -> adder_carry_in=1 during LOAD..CAPTURE, result=0x31, C=0.
3. INC B=0x7F (c_val=0xAA ignored) -> adder_c=0x00, carry_in=1, result=0x80, S=1, Z=0, C=0. overflow_flag=1 with ALU_OVERFLOW_FLAG_EN, 0 without.
4. DEC B=0x00 -> adder_c=0xFF, result=0xFF, C=0, S=1. DEC B=0x05 -> result=0x04, C=1.
5. Second start pulsed every cycle while busy -> exactly one operation completes. The next op begins only on the start after done.
6. Reset asserted in 2nd SETTLE cycle with flags previously set -> next cycle busy=0, all flags/result 0, no load_a/load_d/done pulse ever follows for that op.

Source files
------------

// File: rtl/alu_add_sequencer.sv
// Sequencer for the 8-bit relay adder: latch operands, hold adder inputs through settle, capture sum/flags, strobe destination.
// Optional signed overflow flag: define ALU_OVERFLOW_FLAG_EN.
`timescale 1ns/1ps
module alu_add_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       func,
  input  logic             dest,
  input  logic [WIDTH-1:0] b_val,
  input  logic [WIDTH-1:0] c_val,
  output logic [WIDTH-1:0] adder_b,
  output logic [WIDTH-1:0] adder_c,
  output logic             adder_carry_in,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_carry_out,
  output logic [WIDTH-1:0] result,
  output logic             load_a,
  output logic             load_d,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             overflow_flag
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_INC = 2'b01;
  localparam logic [1:0] F_ADC = 2'b10;
  localparam logic [1:0] F_DEC = 2'b11;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  logic [2:0]       r_state;
  logic [3:0]       r_count;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [1:0]       r_func;
  logic             r_dest;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_sign;

  logic             w_drive;
  logic [WIDTH-1:0] w_effC;
  logic             w_effCin;

  // ADC reads carry_flag live; it cannot change before this op's CAPTURE edge, so the input stays stable.
  always_comb begin
    w_effC   = '0;
    w_effCin = 1'b0;
    case (r_func)
      F_ADD: w_effC = r_c;
      F_INC: begin
        w_effC   = '0;
        w_effCin = 1'b1;
      end
      F_ADC: begin
        w_effC   = r_c;
        w_effCin = r_carry;
      end
      F_DEC: w_effC = '1;
      default: w_effC = '0;
    endcase
  end

  assign w_drive        = (r_state == S_LOAD) || (r_state == S_SETTLE) || (r_state == S_CAPTURE);
  assign adder_b        = w_drive ? r_b : '0;
  assign adder_c        = w_drive ? w_effC : '0;
  assign adder_carry_in = w_drive ? w_effCin : 1'b0;

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign load_a = (r_state == S_CAPTURE) && !r_dest;
  assign load_d = (r_state == S_CAPTURE) && r_dest;

  assign result     = r_result;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign sign_flag  = r_sign;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_func   <= '0;
      r_dest   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_sign   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b     <= b_val;
            r_c     <= c_val;
            r_func  <= func;
            r_dest  <= dest;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_count <= SETTLE_INIT;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_count == 4'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        S_CAPTURE: begin
          r_result <= adder_sum;
          r_carry  <= adder_carry_out;
          r_zero   <= (adder_sum == '0);
          r_sign   <= adder_sum[WIDTH-1];
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  logic r_overflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_overflow <= (adder_b[WIDTH-1] == adder_c[WIDTH-1]) &&
                    (adder_sum[WIDTH-1] != adder_b[WIDTH-1]);
    end
  end

  assign overflow_flag = r_overflow;
`else
  assign overflow_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Directed self-checking bench for alu_add_sequencer; models the external relay adder as a plain combinational adder.
`timescale 1ns/1ps
module tb_alu_add_sequencer;

  localparam int S = 4;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_INC = 2'b01;
  localparam logic [1:0] F_ADC = 2'b10;
  localparam logic [1:0] F_DEC = 2'b11;

`ifdef ALU_OVERFLOW_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] func;
  logic       dest;
  logic [7:0] b_val;
  logic [7:0] c_val;
  logic [7:0] adder_b;
  logic [7:0] adder_c;
  logic       adder_carry_in;
  logic [7:0] adder_sum;
  logic       adder_carry_out;
  logic [7:0] result;
  logic       load_a;
  logic       load_d;
  logic       busy;
  logic       done;
  logic       carry_flag;
  logic       zero_flag;
  logic       sign_flag;
  logic       overflow_flag;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clock = ~clock;

  assign {adder_carry_out, adder_sum} = {1'b0, adder_b} + {1'b0, adder_c} + {8'd0, adder_carry_in};

  alu_add_sequencer #(.WIDTH(8), .SETTLE_CYCLES(S)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .func            (func),
    .dest            (dest),
    .b_val           (b_val),
    .c_val           (c_val),
    .adder_b         (adder_b),
    .adder_c         (adder_c),
    .adder_carry_in  (adder_carry_in),
    .adder_sum       (adder_sum),
    .adder_carry_out (adder_carry_out),
    .result          (result),
    .load_a          (load_a),
    .load_d          (load_d),
    .busy            (busy),
    .done            (done),
    .carry_flag      (carry_flag),
    .zero_flag       (zero_flag),
    .sign_flag       (sign_flag),
    .overflow_flag   (overflow_flag)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] f, input logic d, input logic [7:0] b, input logic [7:0] c);
    @(negedge clock);
    start = 1'b1;
    func  = f;
    dest  = d;
    b_val = b;
    c_val = c;
    @(posedge clock);
    #1;
    start = 1'b0;
    func  = ~f;
    dest  = ~d;
    b_val = ~b;
    c_val = ~c;
  endtask

  // Walks one operation cycle by cycle after the accepting edge: cycle 1 is LOAD, S+2 is CAPTURE, S+3 is DONE.
  task automatic runOp(input string tag, input logic [1:0] f, input logic d,
                       input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] expAdderC, input logic expCin,
                       input logic [7:0] expResult, input logic expC, input logic expZ,
                       input logic expS, input logic expV);
    int loadACount = 0;
    int loadDCount = 0;
    int doneCount  = 0;
    int bothCount  = 0;
    applyStimulus(f, d, b, c);
    for (int m = 1; m <= S + 3; m++) begin
      @(negedge clock);
      if (load_a) loadACount++;
      if (load_d) loadDCount++;
      if (done) doneCount++;
      if ((load_a && load_d) || (done && (load_a || load_d))) bothCount++;
      if (m == 1) begin
        checkOutput({tag, ".load.busy"}, 32'(busy), 32'd1);
        checkOutput({tag, ".load.adder_b"}, 32'(adder_b), 32'(b));
        checkOutput({tag, ".load.adder_c"}, 32'(adder_c), 32'(expAdderC));
        checkOutput({tag, ".load.cin"}, 32'(adder_carry_in), 32'(expCin));
      end
      if (m == S + 2) begin
        checkOutput({tag, ".cap.adder_b"}, 32'(adder_b), 32'(b));
        checkOutput({tag, ".cap.adder_c"}, 32'(adder_c), 32'(expAdderC));
        checkOutput({tag, ".cap.cin"}, 32'(adder_carry_in), 32'(expCin));
        checkOutput({tag, ".cap.load_a"}, 32'(load_a), 32'(!d));
        checkOutput({tag, ".cap.load_d"}, 32'(load_d), 32'(d));
      end
      if (m == S + 3) begin
        checkOutput({tag, ".done"}, 32'(done), 32'd1);
        checkOutput({tag, ".done.adder_b"}, 32'(adder_b), 32'd0);
        checkOutput({tag, ".done.cin"}, 32'(adder_carry_in), 32'd0);
        checkOutput({tag, ".result"}, 32'(result), 32'(expResult));
        checkOutput({tag, ".carry"}, 32'(carry_flag), 32'(expC));
        checkOutput({tag, ".zero"}, 32'(zero_flag), 32'(expZ));
        checkOutput({tag, ".sign"}, 32'(sign_flag), 32'(expS));
        checkOutput({tag, ".overflow"}, 32'(overflow_flag), 32'(expV));
      end
    end
    checkOutput({tag, ".loadACount"}, 32'(loadACount), d ? 32'd0 : 32'd1);
    checkOutput({tag, ".loadDCount"}, 32'(loadDCount), d ? 32'd1 : 32'd0);
    checkOutput({tag, ".doneCount"}, 32'(doneCount), 32'd1);
    checkOutput({tag, ".exclusive"}, 32'(bothCount), 32'd0);
    @(negedge clock);
    checkOutput({tag, ".idle.busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneCount;
    int strayCount;
    reset = 1'b1;
    start = 1'b0;
    func  = 2'b00;
    dest  = 1'b0;
    b_val = 8'h00;
    c_val = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.loads", 32'({load_a, load_d}), 32'd0);
    checkOutput("reset.result", 32'(result), 32'd0);
    checkOutput("reset.flags", 32'({carry_flag, zero_flag, sign_flag, overflow_flag}), 32'd0);
    checkOutput("reset.adder", 32'({adder_b, adder_c, adder_carry_in}), 32'd0);
    reset = 1'b0;

    runOp("add3c05", F_ADD, 1'b0, 8'h3C, 8'h05, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    runOp("addff01", F_ADD, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    runOp("adc1020", F_ADC, 1'b0, 8'h10, 8'h20, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
    runOp("inc7f",   F_INC, 1'b0, 8'h7F, 8'hAA, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, OVF_EN);
    runOp("dec00",   F_DEC, 1'b1, 8'h00, 8'h33, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    runOp("dec05",   F_DEC, 1'b0, 8'h05, 8'h00, 8'hFF, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);

    // start held high through a whole operation: only the first is taken, the next one after done
    @(negedge clock);
    start = 1'b1;
    func  = F_ADD;
    dest  = 1'b0;
    b_val = 8'h01;
    c_val = 8'h02;
    @(posedge clock);
    #1;
    b_val = 8'h50;
    c_val = 8'h07;
    doneCount = 0;
    for (int m = 1; m <= S + 3; m++) begin
      @(negedge clock);
      if (done) doneCount++;
      if (m == S + 3) checkOutput("hold.op1.result", 32'(result), 32'h03);
    end
    checkOutput("hold.op1.doneCount", 32'(doneCount), 32'd1);
    @(negedge clock);
    checkOutput("hold.idle.busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    checkOutput("hold.op2.busy", 32'(busy), 32'd1);
    for (int m = 2; m <= S + 3; m++) begin
      @(negedge clock);
      if (m == S + 2) checkOutput("hold.op2.early", 32'(done), 32'd0);
      if (m == S + 3) begin
        checkOutput("hold.op2.done", 32'(done), 32'd1);
        checkOutput("hold.op2.result", 32'(result), 32'h57);
      end
    end
    @(negedge clock);

    // reset during the second settle cycle after an op that left carry and zero set
    runOp("pre_rst", F_ADD, 1'b0, 8'hFF, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(F_ADD, 1'b0, 8'h11, 8'h22);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.result", 32'(result), 32'd0);
    checkOutput("rst.flags", 32'({carry_flag, zero_flag, sign_flag, overflow_flag}), 32'd0);
    checkOutput("rst.adder", 32'({adder_b, adder_c, adder_carry_in}), 32'd0);
    strayCount = 0;
    for (int m = 0; m < S + 6; m++) begin
      @(negedge clock);
      if (load_a || load_d || done || busy) strayCount++;
    end
    checkOutput("rst.noPulse", 32'(strayCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
